ordered_merge_n: RTL and testbench
==================================

Name: ordered_merge_n

Overview:
- N-channel in-order merger for the encoder output path. Generalises the two-channel varint/raw-data merge stage.
- Each producer channel presents data beats tagged with a sequence index. The block pushes beats into the output FIFO strictly in index order, with parametrised index wrap.
- Adds a data mux, fixed-priority arbitration among same-index channels, a stall watchdog with sticky error, and a soft clear.

Parameters:
NUM_CH, 4, number of producer channels (1..16)
IDX_W, 10, index width in bits
DATA_W, 8, beat data width
IDX_MAX, 2**IDX_W-1, last index value before wrap to 0 (must be <= 2**IDX_W-1)
STALL_MAX, 1024, SCAN cycles with no match before error; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clr  in  1  synchronous soft clear, equivalent to reset
ch_valid  in  NUM_CH  per-channel beat valid
ch_index  in  NUM_CH*IDX_W  per-channel beat index; channel i occupies bits [i*IDX_W +: IDX_W]
ch_last  in  NUM_CH  beat is the final beat of its index
ch_data  in  NUM_CH*DATA_W  per-channel beat data
ch_accept  out  NUM_CH  one-hot accept pulse
out_full  in  1  output FIFO full
out_push  out  1  output FIFO push strobe
out_data  out  DATA_W  output FIFO write data
out_clr  out  1  output FIFO clear
cur_index  out  IDX_W  index currently being emitted
stall_err  out  1  sticky watchdog error

Behaviour:
- Reset is clocked: reset=1 at a rising edge forces state INIT, cur_index=0, stall_cnt=0, sel_q=0, stall_err=0. reset has priority over clr; clr has the same effect from any state.
- Decoded outputs:
  - out_clr=1 whenever state==INIT, including reset cycles.
  - out_push=1 and ch_accept[sel_q]=1 only in PUSH.
  - out_data=ch_data[sel_q] in PUSH, otherwise 0.
  - All other outputs are 0 outside these states.
- Producer rule: ch_valid, ch_index, ch_last and ch_data stay stable from valid assertion until the cycle after the accept pulse.
- match[i] = ch_valid[i] && (ch_index[i]==cur_index). win = lowest i with match[i].
- States:
  - INIT: one cycle → SCAN. cur_index←0, stall_cnt←0.
  - SCAN, any match and !out_full: sel_q←win, stall_cnt←0 → PUSH.
  - SCAN, any match and out_full: stall_cnt←0 → FULL.
  - SCAN, no match and some ch_valid: stall_cnt++. If STALL_MAX!=0 and stall_cnt+1==STALL_MAX → ERROR, stall_err←1.
  - SCAN, no ch_valid: stall_cnt←0, stay.
  - PUSH: one push. If ch_last[sel_q], cur_index←(cur_index==IDX_MAX)?0:cur_index+1. → SCAN.
  - FULL: no push, no accept, no stall counting. Stay while out_full; → SCAN when !out_full.
  - ERROR: hold; stall_err=1; all strobes 0. Leaves only via reset/clr → INIT.
  - Illegal state encoding → INIT.
- Throughput: one beat per 2 cycles (SCAN, PUSH). Latency from matching valid to out_push is 1 cycle when not full.
- Simultaneous matches: lowest channel is served first; the others are re-evaluated in the next SCAN.
- Non-last beats keep cur_index, so one channel may emit several beats for an index. Another channel holding the same index may interleave if it has lower priority number.
- A ch_index > IDX_MAX never matches and ends in the watchdog error.
- Index arithmetic is IDX_W bits unsigned; the wrap compares against IDX_MAX, not overflow.
- clr or reset during PUSH: that push still occurs in the current cycle; the next state is INIT.

Test Plan:
- Ordering: NUM_CH=4. ch0 idx1 last, ch1 idx0 last, ch2 idx2 last, all valid at once → pushes ch1, ch0, ch2 on cycles 2, 4, 6 after INIT; cur_index steps 0→1→2→3.
- Multi-beat plus priority: ch3 sends 3 beats of idx0 (last on the 3rd), ch1 idx0 last also valid → ch1 pushed first and cur_index→1; ch3 then stalls.
  - Repeat with ch1 non-last → ch1, then ch3 ×3; cur_index stays 0 until the 3rd ch3 beat.
- Backpressure: out_full=1 with ch0 idx0 valid → FULL, out_push=0 and ch_accept=0 for 10 cycles, stall_err=0. Drop out_full → SCAN, then PUSH on the 2nd cycle after.
- Wrap: IDX_MAX=5. Feed idx 0..5 last, then idx 0 → cur_index 5→0 and the idx0 beat is pushed; idx 6 is never pushed.
- Watchdog: STALL_MAX=8, ch0 valid idx3, cur_index=0 → stall_err rises after the 8th SCAN cycle, no pushes. Pulse clr → out_clr=1 for one cycle, stall_err=0, cur_index=0.
- Reset mid-stream: assert reset in a PUSH cycle → that push occurs; afterwards state INIT, out_clr=1, cur_index=0; the next push follows the original index order.

Source files
------------

// File: rtl/ordered_merge_n.sv
// ordered_merge_n
// N-channel in-order merger for the encoder output path. Each producer
// channel offers beats tagged with a sequence index; beats are pushed into
// the output FIFO strictly in index order, wrapping after IDX_MAX. Among
// channels holding the current index the lowest channel number wins.
// A watchdog flags a sticky error when valid beats sit unmatched for
// STALL_MAX scan cycles (0 disables it).
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset (priority over clr)
//   clr        synchronous soft clear, same effect as reset
//   ch_valid   per-channel beat valid
//   ch_index   per-channel beat index, channel i at [i*IDX_W +: IDX_W]
//   ch_last    beat is the final beat of its index
//   ch_data    per-channel beat data, channel i at [i*DATA_W +: DATA_W]
//   ch_accept  one-hot accept pulse to the served channel
//   out_full   output FIFO full
//   out_push   output FIFO push strobe
//   out_data   output FIFO write data
//   out_clr    output FIFO clear (asserted while in INIT)
//   cur_index  index currently being emitted
//   stall_err  sticky watchdog error
module ordered_merge_n #(
   parameter int          NUM_CH    = 4,
   parameter int          IDX_W     = 10,
   parameter int          DATA_W    = 8,
   parameter int unsigned IDX_MAX   = 2**IDX_W - 1,
   parameter int unsigned STALL_MAX = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*IDX_W-1:0]  ch_index,
   input  logic [NUM_CH-1:0]        ch_last,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_accept,
   input  logic                     out_full,
   output logic                     out_push,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_clr,
   output logic [IDX_W-1:0]         cur_index,
   output logic                     stall_err
);

   localparam int SEL_W = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);
   localparam int CNT_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
   localparam logic [IDX_W-1:0] L_IDX_MAX = IDX_W'(IDX_MAX);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_SCAN  = 3'd1,
      S_PUSH  = 3'd2,
      S_FULL  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_cur_index, w_cur_index_nxt;
   logic [CNT_W-1:0]   r_stall_cnt, w_stall_cnt_nxt;
   logic [SEL_W-1:0]   r_sel, w_sel_nxt;
   logic               r_stall_err, w_stall_err_nxt;

   logic [NUM_CH-1:0]  w_match;
   logic [SEL_W-1:0]   w_win;
   logic [CNT_W-1:0]   w_stall_inc;
   logic               w_stall_hit;

   // Match against the current index; indices above IDX_MAX can never
   // equal r_cur_index, so they fall through to the watchdog.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_match[i] = ch_valid[i] && (ch_index[i*IDX_W +: IDX_W] == r_cur_index);
      end
   end

   // Fixed priority: scanning from the top down leaves the lowest match.
   always_comb begin
      w_win = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (w_match[NUM_CH-1-i]) w_win = SEL_W'(NUM_CH-1-i);
      end
   end

   assign w_stall_inc = r_stall_cnt + CNT_W'(1);
   assign w_stall_hit = (STALL_MAX != 0) && (w_stall_inc == CNT_W'(STALL_MAX));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_state     <= S_INIT;
         r_cur_index <= '0;
         r_stall_cnt <= '0;
         r_sel       <= '0;
         r_stall_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_index <= w_cur_index_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_sel       <= w_sel_nxt;
         r_stall_err <= w_stall_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cur_index_nxt = r_cur_index;
      w_stall_cnt_nxt = r_stall_cnt;
      w_sel_nxt       = r_sel;
      w_stall_err_nxt = r_stall_err;
      case (r_state)
         S_INIT: begin
            w_cur_index_nxt = '0;
            w_stall_cnt_nxt = '0;
            w_state_nxt     = S_SCAN;
         end
         S_SCAN: begin
            if (|w_match) begin
               w_stall_cnt_nxt = '0;
               if (out_full) begin
                  w_state_nxt = S_FULL;
               end else begin
                  w_sel_nxt   = w_win;
                  w_state_nxt = S_PUSH;
               end
            end else if (|ch_valid) begin
               w_stall_cnt_nxt = w_stall_inc;
               if (w_stall_hit) begin
                  w_stall_err_nxt = 1'b1;
                  w_state_nxt     = S_ERROR;
               end
            end else begin
               w_stall_cnt_nxt = '0;
            end
         end
         S_PUSH: begin
            if (ch_last[r_sel]) begin
               w_cur_index_nxt = (r_cur_index == L_IDX_MAX) ? '0
                                                           : r_cur_index + IDX_W'(1);
            end
            w_state_nxt = S_SCAN;
         end
         S_FULL: begin
            if (!out_full) w_state_nxt = S_SCAN;
         end
         S_ERROR: begin
            w_stall_err_nxt = 1'b1;
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      ch_accept = '0;
      out_push  = 1'b0;
      out_data  = '0;
      if (r_state == S_PUSH) begin
         ch_accept[r_sel] = 1'b1;
         out_push         = 1'b1;
         out_data         = ch_data[r_sel*DATA_W +: DATA_W];
      end
   end

   assign out_clr   = (r_state == S_INIT);
   assign cur_index = r_cur_index;
   assign stall_err = r_stall_err;

endmodule

// File: tb/tb_ordered_merge_n.sv
// Directed bench for ordered_merge_n: ordering, multi-beat priority,
// backpressure, index wrap, watchdog with soft clear, reset mid-push.
// Configured with 4 channels, 3-bit index, IDX_MAX=5, STALL_MAX=8.
module tb_ordered_merge_n;

   localparam int NC = 4;
   localparam int IW = 3;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clr = 1'b0;
   logic [NC-1:0]    ch_valid = '0;
   logic [NC*IW-1:0] ch_index = '0;
   logic [NC-1:0]    ch_last = '0;
   logic [NC*DW-1:0] ch_data = '0;
   logic [NC-1:0]    ch_accept;
   logic             out_full = 1'b0;
   logic             out_push;
   logic [DW-1:0]    out_data;
   logic             out_clr;
   logic [IW-1:0]    cur_index;
   logic             stall_err;

   int checks = 0;
   int errors = 0;

   ordered_merge_n #(
      .NUM_CH(NC), .IDX_W(IW), .DATA_W(DW), .IDX_MAX(5), .STALL_MAX(8)
   ) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .ch_valid(ch_valid), .ch_index(ch_index), .ch_last(ch_last),
      .ch_data(ch_data), .ch_accept(ch_accept), .out_full(out_full),
      .out_push(out_push), .out_data(out_data), .out_clr(out_clr),
      .cur_index(cur_index), .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic v, input int idx,
                         input logic last, input int data);
      ch_valid[ch]           = v;
      ch_index[ch*IW +: IW]  = IW'(idx);
      ch_last[ch]            = last;
      ch_data[ch*DW +: DW]   = DW'(data);
   endtask

   task automatic expect_push(input string tag, input int ch, input int data);
      chk({tag, "_push"},   32'(out_push), 32'd1);
      chk({tag, "_accept"}, 32'(ch_accept), 32'(1 << ch));
      chk({tag, "_data"},   32'(out_data), 32'(data));
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_push"},   32'(out_push), 32'd0);
      chk({tag, "_accept"}, 32'(ch_accept), 32'd0);
      chk({tag, "_data"},   32'(out_data), 32'd0);
   endtask

   // Leaves the DUT in INIT with reset released and all channels idle.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      ch_valid = '0;
      out_full = 1'b0;
      tick();
      chk({tag, "_rst_clr"}, 32'(out_clr), 32'd1);
      chk({tag, "_rst_idx"}, 32'(cur_index), 32'd0);
      chk({tag, "_rst_err"}, 32'(stall_err), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      // ---------------- ordering ----------------
      do_reset("ord");
      expect_idle("ord_init");
      set_ch(0, 1'b1, 1, 1'b1, 8'hA0);
      set_ch(1, 1'b1, 0, 1'b1, 8'hB1);
      set_ch(2, 1'b1, 2, 1'b1, 8'hC2);
      tick();                                   // cycle 1: SCAN
      chk("ord_scan_clr", 32'(out_clr), 32'd0);
      expect_idle("ord_scan");
      tick();                                   // cycle 2: push ch1
      expect_push("ord_p1", 1, 8'hB1);
      chk("ord_idx_p1", 32'(cur_index), 32'd0);
      tick();
      chk("ord_idx1", 32'(cur_index), 32'd1);
      ch_valid[1] = 1'b0;
      tick();                                   // cycle 4: push ch0
      expect_push("ord_p2", 0, 8'hA0);
      tick();
      chk("ord_idx2", 32'(cur_index), 32'd2);
      ch_valid[0] = 1'b0;
      tick();                                   // cycle 6: push ch2
      expect_push("ord_p3", 2, 8'hC2);
      tick();
      chk("ord_idx3", 32'(cur_index), 32'd3);
      ch_valid[2] = 1'b0;
      tick();
      expect_idle("ord_done");

      // ---------------- multi-beat, ch1 last ----------------
      do_reset("mb1");
      set_ch(3, 1'b1, 0, 1'b0, 8'h31);
      set_ch(1, 1'b1, 0, 1'b1, 8'h11);
      tick();
      tick();
      expect_push("mb1_p1", 1, 8'h11);
      tick();
      chk("mb1_idx", 32'(cur_index), 32'd1);
      ch_valid[1] = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         tick();
         expect_idle("mb1_stall");
         chk("mb1_stall_idx", 32'(cur_index), 32'd1);
      end

      // ---------------- multi-beat, ch1 non-last ----------------
      do_reset("mb2");
      set_ch(3, 1'b1, 0, 1'b0, 8'h31);
      set_ch(1, 1'b1, 0, 1'b0, 8'h11);
      tick();
      tick();
      expect_push("mb2_p1", 1, 8'h11);
      tick();
      chk("mb2_idx_a", 32'(cur_index), 32'd0);
      ch_valid[1] = 1'b0;
      tick();
      expect_push("mb2_p2", 3, 8'h31);
      tick();
      chk("mb2_idx_b", 32'(cur_index), 32'd0);
      set_ch(3, 1'b1, 0, 1'b0, 8'h32);
      tick();
      expect_push("mb2_p3", 3, 8'h32);
      tick();
      chk("mb2_idx_c", 32'(cur_index), 32'd0);
      set_ch(3, 1'b1, 0, 1'b1, 8'h33);
      tick();
      expect_push("mb2_p4", 3, 8'h33);
      chk("mb2_idx_d", 32'(cur_index), 32'd0);
      tick();
      chk("mb2_idx_e", 32'(cur_index), 32'd1);
      ch_valid[3] = 1'b0;

      // ---------------- backpressure ----------------
      do_reset("bp");
      set_ch(0, 1'b1, 0, 1'b1, 8'h55);
      out_full = 1'b1;
      tick();                                   // SCAN
      expect_idle("bp_scan");
      for (int unsigned k = 0; k < 10; k++) begin
         tick();                                // FULL
         expect_idle("bp_full");
         chk("bp_err", 32'(stall_err), 32'd0);
      end
      out_full = 1'b0;
      tick();                                   // back to SCAN
      expect_idle("bp_rescan");
      tick();
      expect_push("bp_push", 0, 8'h55);
      tick();
      chk("bp_idx", 32'(cur_index), 32'd1);
      ch_valid[0] = 1'b0;

      // ---------------- wrap at IDX_MAX=5, idx 6 never served ----------------
      do_reset("wr");
      set_ch(0, 1'b1, 0, 1'b1, 8'h10);
      set_ch(1, 1'b1, 6, 1'b1, 8'hEE);
      tick();
      for (int unsigned k = 0; k < 7; k++) begin
         tick();
         expect_push("wr_push", 0, int'(8'h10 + k));
         tick();
         chk("wr_idx", 32'(cur_index), 32'((k + 1) % 6));
         set_ch(0, 1'b1, int'((k + 1) % 6), 1'b1, int'(8'h11 + k));
      end
      ch_valid[0] = 1'b0;
      tick();
      expect_idle("wr_idx6");

      // ---------------- watchdog and soft clear ----------------
      do_reset("wd");
      set_ch(0, 1'b1, 3, 1'b1, 8'h77);
      for (int unsigned k = 0; k < 8; k++) begin
         tick();                                // SCAN cycles 1..8
         expect_idle("wd_scan");
         chk("wd_noerr", 32'(stall_err), 32'd0);
      end
      tick();
      chk("wd_err", 32'(stall_err), 32'd1);
      expect_idle("wd_errstate");
      tick();
      chk("wd_err_hold", 32'(stall_err), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("wd_clr_outclr", 32'(out_clr), 32'd1);
      chk("wd_clr_err", 32'(stall_err), 32'd0);
      chk("wd_clr_idx", 32'(cur_index), 32'd0);
      tick();
      chk("wd_clr_once", 32'(out_clr), 32'd0);
      ch_valid[0] = 1'b0;

      // ---------------- reset during a PUSH ----------------
      do_reset("rm");
      set_ch(0, 1'b1, 1, 1'b1, 8'hA0);
      set_ch(1, 1'b1, 0, 1'b1, 8'hB1);
      set_ch(2, 1'b1, 2, 1'b1, 8'hC2);
      tick();
      tick();
      reset = 1'b1;
      #1;
      expect_push("rm_push_in_reset", 1, 8'hB1);
      tick();
      reset = 1'b0;
      chk("rm_clr", 32'(out_clr), 32'd1);
      chk("rm_idx", 32'(cur_index), 32'd0);
      tick();                                   // SCAN, stream restarts at idx 0
      tick();
      expect_push("rm_p1", 1, 8'hB1);
      tick();
      chk("rm_idx1", 32'(cur_index), 32'd1);
      ch_valid[1] = 1'b0;
      tick();
      expect_push("rm_p2", 0, 8'hA0);
      tick();
      ch_valid[0] = 1'b0;
      tick();
      expect_push("rm_p3", 2, 8'hC2);
      tick();
      chk("rm_idx3", 32'(cur_index), 32'd3);
      ch_valid[2] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
